// File: rtl/timer_counter_pkg.sv
// -----------------------------------------------------------------------------
// timer_counter_pkg
// Shared constants for the memory-mapped down-counter timer:
//   - word offsets of the three registers (bus addr[3:2])
//   - CTRL bit positions and MODE codes
//   - 2-bit FSM state encodings
// No ports; imported by timer_counter.
// -----------------------------------------------------------------------------
package timer_counter_pkg;

  // Register word offsets
  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;
  localparam logic [1:0] TC_RSVD   = 2'd3;

  // CTRL register layout (only the low four bits exist)
  localparam int CTRL_W        = 4;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  // MODE codes; the two codes with MODE[1]=1 behave as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

endpackage

// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
// Memory-mapped 32-bit down-counter with interrupt on the CPU data-side bus.
// Registers: CTRL @0x0 (EN, MODE, IM), PRESET @0x4, COUNT @0x8 (read-only),
// 0xC reserved (reads 0, writes dropped).
//
// Ports:
//   clk     in   1   system clock, all state on rising edge
//   reset   in   1   asynchronous active-low reset (0 = reset)
//   sel     in   1   bridge select, block addressed this cycle
//   addr    in   2   word offset (bus addr[3:2])
//   we      in   1   write strobe, qualified by sel
//   byteen  in   4   per-byte write enables, byteen[i] -> wdata[8i+7:8i]
//   wdata   in   32  write data
//   rdata   out  32  read data, combinational from addr (ignores sel)
//   irq     out  1   interrupt request (IM & irq_flag), registered
// -----------------------------------------------------------------------------
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] RESET_PRESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  // ---------------------------------------------------------------------------
  // Byte-enable merge: bytes with byteen=1 come from the bus, the rest keep
  // their old value.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_val,
    input logic [31:0] new_val,
    input logic [3:0]  be
  );
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_val[8*i +: 8];
      end
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CTRL_W-1:0] ctrl_reg,     ctrl_next;
  logic [31:0]       preset_reg,   preset_next;
  logic [31:0]       count_reg,    count_next;
  logic [1:0]        state_reg,    state_next;
  logic              irq_flag_reg, irq_flag_next;
  logic              irq_reg,      irq_next;

  // CTRL as the FSM would leave it, before any bus write is applied
  logic [CTRL_W-1:0] ctrl_fsm;

  // ---------------------------------------------------------------------------
  // Decoded controls
  // ---------------------------------------------------------------------------
  logic       ctrl_wr;
  logic       preset_wr;
  logic       en;
  logic [1:0] mode;
  logic       auto_reload;

  assign ctrl_wr     = sel & we & (addr == TC_CTRL);
  assign preset_wr   = sel & we & (addr == TC_PRESET);
  assign en          = ctrl_reg[CTRL_EN];
  assign mode        = ctrl_reg[CTRL_MODE_MSB:CTRL_MODE_LSB];
  // MODE codes other than 01 fall back to one-shot behaviour
  assign auto_reload = (mode == MODE_RELOAD);

  // ---------------------------------------------------------------------------
  // FSM, counter and register next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    ctrl_fsm      = ctrl_reg;
    irq_flag_next = irq_flag_reg;

    // In auto-reload the flag is a single-cycle pulse: anything set in INT
    // drops again on the following edge.
    if (auto_reload && (state_reg != ST_INT)) begin
      irq_flag_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        // Always restart through LOAD so a re-enable reloads PRESET
        if (en) begin
          state_next = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // Uses the PRESET value registered before this edge, so a PRESET
        // write on the same edge only affects the next LOAD.
        count_next = preset_reg;
        state_next = ST_CNT;
      end

      ST_CNT: begin
        if (!en) begin
          state_next = ST_IDLE;
        end else if (count_reg > 32'd1) begin
          count_next = count_reg - 32'd1;
        end else begin
          // Covers COUNT=1 and COUNT=0 (PRESET=0): never wraps below zero
          count_next = 32'd0;
          state_next = ST_INT;
        end
      end

      ST_INT: begin
        irq_flag_next = 1'b1;
        if (auto_reload) begin
          state_next = ST_LOAD;
        end else begin
          ctrl_fsm[CTRL_EN] = 1'b0;
          state_next        = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // A bus write to CTRL overrides every bit the FSM might have touched,
    // including the EN clear in INT. Only byte 0 holds implemented bits.
    ctrl_next = ctrl_fsm;
    if (ctrl_wr && byteen[0]) begin
      ctrl_next = wdata[CTRL_W-1:0];
    end

    preset_next = preset_reg;
    if (preset_wr) begin
      preset_next = merge_bytes(preset_reg, wdata, byteen);
    end

    // Any CTRL or PRESET access acknowledges the interrupt, and wins over a
    // flag set by INT on the same edge.
    if (ctrl_wr || preset_wr) begin
      irq_flag_next = 1'b0;
    end

    // irq is registered from the next-state values so it always equals
    // IM & irq_flag as seen on the registers.
    irq_next = ctrl_next[CTRL_IM] & irq_flag_next;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_reg     <= '0;
      preset_reg   <= RESET_PRESET;
      count_reg    <= '0;
      state_reg    <= ST_IDLE;
      irq_flag_reg <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      ctrl_reg     <= ctrl_next;
      preset_reg   <= preset_next;
      count_reg    <= count_next;
      state_reg    <= state_next;
      irq_flag_reg <= irq_flag_next;
      irq_reg      <= irq_next;
    end
  end

  assign irq = irq_reg;

  // ---------------------------------------------------------------------------
  // Read mux, zero latency, independent of sel
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = 32'd0;
    case (addr)
      TC_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl_reg};
      TC_PRESET: rdata = preset_reg;
      TC_COUNT:  rdata = count_reg;
      TC_RSVD:   rdata = 32'd0;
      default:   rdata = 32'd0;
    endcase
  end

endmodule
